// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the parameterised sequence detector
package seq_det_pkg;

  // Values of the overlap input
  localparam logic MODE_NONOVERLAP = 1'b0;
  localparam logic MODE_OVERLAP    = 1'b1;

  // Pattern and length restored by reset: the classic "101"
  localparam logic [7:0] DEF_RST_PAT = 8'b0000_0101;
  localparam int         DEF_RST_LEN = 3;

  // Width needed to hold a length or fill value in 0..pat_w
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// rtl/seq_hist_shreg.sv - bit history shift register with saturating fill counter
module seq_hist_shreg #(
  parameter int PAT_W  = 8,
  parameter int FILL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_i,     // consume d_i this cycle
  input  logic              d_i,
  input  logic              clr_fill_i,  // with shift_i: keep the bit but restart the fill count
  input  logic              clr_all_i,   // drop history and fill; wins over shift_i
  output logic [PAT_W-1:0]  hist_nxt_o,  // history as it will be once d_i is shifted in
  output logic [FILL_W-1:0] fill_nxt_o,  // fill as it will be once d_i is shifted in
  output logic [FILL_W-1:0] fill_o
);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;

  // A single-bit history degenerates to just the newest bit
  generate
    if (PAT_W == 1) begin : g_one
      assign hist_shift = d_i;
    end else begin : g_many
      assign hist_shift = {hist_q[PAT_W-2:0], d_i};
    end
  endgenerate

  assign fill_inc   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
  assign hist_nxt_o = hist_shift;
  assign fill_nxt_o = fill_inc;
  assign fill_o     = fill_q;

  // Next history/fill: clear beats shift, otherwise hold
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_all_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = hist_shift;
      fill_d = clr_fill_i ? '0 : fill_inc;
    end
  end

  // History and fill registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - loadable-pattern serial detector with saturating match counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
  parameter int               RST_LEN = DEF_RST_LEN,
  localparam int              LEN_W   = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             overlap,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             armed_q, armed_d;

  logic [PAT_W-1:0] hist_nxt;
  logic [LEN_W-1:0] fill_nxt, fill_cur, fill_d;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len_clamped;
  logic             shift, clr_fill, hit;

  // A sample arriving together with a load is discarded
  assign shift = en & ~load;

  seq_hist_shreg #(
    .PAT_W  (PAT_W),
    .FILL_W (LEN_W)
  ) u_hist (
    .clk        (clk),
    .rst        (rst),
    .shift_i    (shift),
    .d_i        (d),
    .clr_fill_i (clr_fill),
    .clr_all_i  (load),
    .hist_nxt_o (hist_nxt),
    .fill_nxt_o (fill_nxt),
    .fill_o     (fill_cur)
  );

  // Masked compare of the post-shift history against the active pattern
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    hit      = (fill_nxt >= len_q) && ((hist_nxt & mask) == (pat_q & mask));
    match_d  = shift & hit;
    clr_fill = match_d & (overlap == MODE_NONOVERLAP);
  end

  // Pattern/length load with out-of-range lengths taken as the full width
  always_comb begin
    len_clamped = len_in;
    if ((len_in == '0) || (len_in > LEN_W'(PAT_W))) begin
      len_clamped = LEN_W'(PAT_W);
    end
    pat_d = pat_q;
    len_d = len_q;
    if (load) begin
      pat_d = pat_in;
      len_d = len_clamped;
    end
  end

  // Armed tracks whether the history will hold a full pattern's worth of bits
  always_comb begin
    fill_d = fill_cur;
    if (load) begin
      fill_d = '0;
    end else if (shift) begin
      fill_d = clr_fill ? '0 : fill_nxt;
    end
    armed_d = (fill_d >= len_d);
  end

  // Saturating counter; a clear coinciding with a match leaves one match counted
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = match_d ? CNT_W'(1) : '0;
    end else if (match_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output and configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= RST_PAT;
      len_q   <= LEN_W'(RST_LEN);
      cnt_q   <= '0;
      match_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      armed_q <= armed_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       d = 1'b0;
  logic       overlap = 1'b0;
  logic       load = 1'b0;
  logic [7:0] pat_in = 8'h00;
  logic [3:0] len_in = 4'd0;
  logic       clr_cnt = 1'b0;

  logic       match, armed;
  logic [7:0] match_count;
  logic       match2, armed2;
  logic [1:0] count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .d           (d),
    .overlap     (overlap),
    .load        (load),
    .pat_in      (pat_in),
    .len_in      (len_in),
    .clr_cnt     (clr_cnt),
    .match       (match),
    .match_count (match_count),
    .armed       (armed)
  );

  seq_detector_param #(.PAT_W(8), .CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .d           (d),
    .overlap     (overlap),
    .load        (load),
    .pat_in      (pat_in),
    .len_in      (len_in),
    .clr_cnt     (clr_cnt),
    .match       (match2),
    .match_count (count2),
    .armed       (armed2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    clr_cnt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l);
    load = 1'b1;
    pat_in = p;
    len_in = l;
    tick();
    load = 1'b0;
  endtask

  // bits/exp_m are read MSB-first over n entries; exp_m is the expected match after each bit
  task automatic send_seq(input string tag, input int n, input logic [15:0] bits, input logic [15:0] exp_m);
    for (int i = n - 1; i >= 0; i--) begin
      en = 1'b1;
      d = bits[i];
      tick();
      en = 1'b0;
      d = 1'b0;
      check($sformatf("%s_b%0d", tag, n - i), 32'(match), 32'(exp_m[i]));
    end
  endtask

  initial begin
    // 1: reset state, overlapping 10101
    do_reset();
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    overlap = 1'b1;
    send_seq("t1", 5, 16'b10101, 16'b00101);
    check("t1_count", 32'(match_count), 32'd2);
    check("t1_armed", 32'(armed), 32'd1);
    tick();
    check("t1_pulse_end", 32'(match), 32'd0);

    // 2: non-overlapping
    do_reset();
    overlap = 1'b0;
    send_seq("t2a", 5, 16'b10101, 16'b00100);
    check("t2a_count", 32'(match_count), 32'd1);
    send_seq("t2b", 6, 16'b101101, 16'b001001);
    check("t2b_count", 32'(match_count), 32'd3);

    // 3: 8-bit pattern B2 with an en gap in the middle
    overlap = 1'b1;
    do_load(8'hB2, 4'd8);
    check("t3_load_armed", 32'(armed), 32'd0);
    send_seq("t3a", 4, 16'b1011, 16'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_gap%0d_match", i), 32'(match), 32'd0);
      check($sformatf("t3_gap%0d_armed", i), 32'(armed), 32'd0);
    end
    send_seq("t3b", 3, 16'b001, 16'b000);
    check("t3_armed_7", 32'(armed), 32'd0);
    send_seq("t3c", 1, 16'b0, 16'b1);
    check("t3_armed_8", 32'(armed), 32'd1);
    check("t3_count", 32'(match_count), 32'd4);

    // 4: len 0 clamps to 8; load beats a same-cycle sample; len 15 clamps too
    do_load(8'hFF, 4'd0);
    send_seq("t4a", 7, 16'b1111111, 16'b0000000);
    send_seq("t4b", 1, 16'b1, 16'b1);
    check("t4_count", 32'(match_count), 32'd5);
    load = 1'b1;
    en = 1'b1;
    d = 1'b1;
    tick();
    load = 1'b0;
    en = 1'b0;
    check("t4_loaden_match", 32'(match), 32'd0);
    check("t4_loaden_armed", 32'(armed), 32'd0);
    send_seq("t4c", 7, 16'b1111111, 16'b0000000);
    send_seq("t4d", 1, 16'b1, 16'b1);
    check("t4_count2", 32'(match_count), 32'd6);
    do_load(8'h00, 4'd15);
    send_seq("t4e", 8, 16'b00000000, 16'b00000001);
    check("t4_count3", 32'(match_count), 32'd7);

    // 5: counter saturation on the 2-bit instance and clear on a match cycle
    do_reset();
    overlap = 1'b1;
    send_seq("t5", 11, 16'b10101010101, 16'b00101010101);
    check("t5_count8", 32'(match_count), 32'd5);
    check("t5_count2", 32'(count2), 32'd3);
    send_seq("t5b", 1, 16'b0, 16'b0);
    clr_cnt = 1'b1;
    send_seq("t5c", 1, 16'b1, 16'b1);
    clr_cnt = 1'b0;
    check("t5_clr_count8", 32'(match_count), 32'd1);
    check("t5_clr_count2", 32'(count2), 32'd1);

    // 6: reset mid-sequence drops the partial history and overrides en
    do_reset();
    send_seq("t6a", 2, 16'b10, 16'b00);
    rst = 1'b1;
    en = 1'b1;
    d = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b0;
    check("t6_rst_match", 32'(match), 32'd0);
    check("t6_rst_armed", 32'(armed), 32'd0);
    check("t6_rst_count", 32'(match_count), 32'd0);
    send_seq("t6b", 1, 16'b1, 16'b0);
    send_seq("t6c", 2, 16'b01, 16'b01);
    check("t6_count", 32'(match_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parameterised serial pattern detector, successor to the fixed 3-bit "101" Moore detector.
- Detects a run-time-loadable bit pattern of programmable length (1..PAT_W) on a qualified serial input.
- Supports overlapping and non-overlapping detection modes.
- Keeps a saturating match counter.
- Sits on a serial bit stream behind a sampler or deserialiser and flags frame/sync words to downstream control logic.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=1)
CNT_W, 8, width of saturating match counter
RST_PAT, 8'b0000_0101, pattern loaded at reset ("101")
RST_LEN, 3, pattern length loaded at reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
en  in  1  sample qualifier; d is consumed only when en=1
d  in  1  serial data bit
overlap  in  1  1 = overlapping detection, 0 = non-overlapping
load  in  1  pattern load strobe
pat_in  in  PAT_W  new pattern; low len_in bits used
len_in  in  $clog2(PAT_W+1)  new pattern length
clr_cnt  in  1  clear match counter
match  out  1  registered one-cycle pulse on detection
match_count  out  CNT_W  saturating number of matches
armed  out  1  history holds >= current length valid bits

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst.
- Reset state: match=0, match_count=0, armed=0, history=0, fill=0, pattern=RST_PAT, length=RST_LEN.
- Bit order is MSB-first: for length L, pat[L-1] is the first bit received and pat[0] the last.
- History is a PAT_W shift register. On each en=1 cycle: hist <= {hist[PAT_W-2:0], d}. fill increments, saturating at PAT_W.
- Match condition, evaluated on the updated history: fill_next >= L and hist_next[L-1:0] == pat[L-1:0].
- match is registered: it is high in the cycle after the clock edge that consumed the completing bit. Latency is 1 cycle. It pulses for exactly one cycle per match.
- en=0 cycles hold all state and force match=0. Gaps in en do not break a partial sequence.
- overlap=1: history is kept after a match, so suffix bits count toward the next match.
- overlap=0: on a match, fill is cleared to 0, so the next match needs L fresh bits.
- overlap is sampled per bit and may change at any time.
- match_count increments on each match, saturating at 2^CNT_W-1.
- clr_cnt clears the counter. If clr_cnt and a match occur in the same cycle, the count becomes 1.
- load=1 sets pattern <= pat_in and length <= clamp(len_in), then clears fill and history.
- Length clamp: len_in=0 or len_in>PAT_W is loaded as PAT_W.
- If load and en occur in the same cycle, load wins: the sample is discarded and match=0.
- Loading does not affect match_count.
- armed = (fill >= L), registered.
- rst overrides every other input. A reset mid-sequence discards the partial history.
- All outputs come from registers. There is no combinational path from an input to an output.

Decomposition:
Shared package (seq_det_pkg):
- MODE_OVERLAP / MODE_NONOVERLAP constants.
- Length-width function clog2(PAT_W+1).
- Default RST_PAT and RST_LEN constants.

Sub-module seq_hist_shreg:
- Contains the PAT_W shift register plus the fill counter, with shift/clear controls.
- Outputs hist and fill.
- The top level holds the pattern/length registers, the masked compare, the match register and the counter.

Test Plan:
1. rst=1 for 2 cycles -> match=0, match_count=0, armed=0. Then overlap=1, en=1, d stream 1,0,1,0,1 -> match pulses 1 cycle after the 3rd and 5th bits, match_count=2.
2. After reset, overlap=0, stream 1,0,1,0,1 -> single match after the 3rd bit, count=1. Then stream 1,0,1,1,0,1 -> matches after the 3rd and 6th bits, count=3.
3. load=1, pat_in=8'hB2, len_in=8. Then stream 1,0,1,1 then en=0 for 3 cycles, then 0,0,1,0 -> one match after the final bit, armed=1 from the 8th bit on.
4. load=1, len_in=0, pat_in=8'hFF -> length clamps to 8. Seven 1s give no match; the eighth gives a match. load asserted together with en=1, d=1 -> sample dropped, fill=0.
5. With CNT_W=2, overlap=1, default pattern, stream 1,0,1,0,1,0,1,0,1,0,1 -> 5 matches, match_count saturates at 3. clr_cnt on a match cycle -> count=1.
6. Feed 1,0 and assert rst for 1 cycle, then feed 1 -> no match. Then 0,1 -> match, count=1.
